// File: rtl/fir_filter_pkg.sv
// Shared sizing helpers and sample type for the multi-channel FIR delay line.
package fir_filter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  // Channel index width; never narrower than one bit so a single channel still has a port.
  function automatic int chan_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Number of symmetric pre-add outputs: ceil(taps / 2).
  function automatic int fold_n(input int taps);
    return (taps + 1) / 2;
  endfunction

  // Default signed sample type; wider instances use logic [DataWidth-1:0] directly.
  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/fir_delay_line_chan.sv
// One channel of the delay line: TapsNum sample registers plus a saturating fill counter.
// The post-update (next-state) values are exported so the top can capture them in the
// same cycle the shift happens.
module fir_delay_line_chan
  import fir_filter_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int TapsNum   = 10,
  localparam int CntW     = $clog2(TapsNum + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              shift_en,
  input  logic [DataWidth-1:0]              din,
  output logic [TapsNum-1:0][DataWidth-1:0] taps_next,
  output logic [CntW-1:0]                   count_next
);

  logic [TapsNum-1:0][DataWidth-1:0] taps_q, taps_d;
  logic [CntW-1:0]                   count_q, count_d;

  // Next state: clear wins, otherwise shift the newest sample into slot 0 and count up.
  always_comb begin
    taps_d  = taps_q;
    count_d = count_q;
    if (clear) begin
      taps_d  = '0;
      count_d = '0;
    end else if (shift_en) begin
      taps_d = {taps_q[TapsNum-2:0], din};
      if (count_q != CntW'(TapsNum)) begin
        count_d = count_q + CntW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      taps_q  <= '0;
      count_q <= '0;
    end else begin
      taps_q  <= taps_d;
      count_q <= count_d;
    end
  end

  assign taps_next  = taps_d;
  assign count_next = count_d;

endmodule

// File: rtl/fir_delay_line_mc.sv
// Time-division-multiplexed FIR delay line: per-channel shift registers, a single
// valid/ready output register carrying the updated tap set, optional symmetric fold.
module fir_delay_line_mc
  import fir_filter_pkg::*;
#(
  parameter int  DataWidth   = 16,
  parameter int  TapsNum     = 10,
  parameter int  ChannelsNum = 4,
  parameter bit  Fold        = 1'b0,
  localparam int CHAN_W      = chan_w(ChannelsNum),
  localparam int FOLD_N      = fold_n(TapsNum)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CHAN_W-1:0]                 in_chan,
  input  logic [DataWidth-1:0]              din,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHAN_W-1:0]                 out_chan,
  output logic                              out_primed,
  output logic [TapsNum-1:0][DataWidth-1:0] taps,
  output logic [FOLD_N-1:0][DataWidth:0]    fold,
  output logic                              chan_err
);

  localparam int CntW = $clog2(TapsNum + 1);

  logic                              accept;
  logic                              chan_ok;
  logic [ChannelsNum-1:0]            shift_en;
  logic [TapsNum-1:0][DataWidth-1:0] chan_taps  [ChannelsNum];
  logic [CntW-1:0]                   chan_count [ChannelsNum];
  logic [TapsNum-1:0][DataWidth-1:0] sel_taps;
  logic [CntW-1:0]                   sel_count;

  logic                              out_valid_q, out_valid_d;
  logic [CHAN_W-1:0]                 out_chan_q, out_chan_d;
  logic                              out_primed_q, out_primed_d;
  logic [TapsNum-1:0][DataWidth-1:0] taps_q, taps_d;
  logic                              chan_err_q, chan_err_d;

  // Accept only when not flushing and the output slot is free or draining this cycle.
  assign in_ready = rst & ~clear & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign chan_ok  = ({1'b0, in_chan} < (CHAN_W + 1)'(ChannelsNum));

  for (genvar gi = 0; gi < ChannelsNum; gi++) begin : g_chan
    assign shift_en[gi] = accept & chan_ok & (in_chan == CHAN_W'(gi));

    fir_delay_line_chan #(
      .DataWidth (DataWidth),
      .TapsNum   (TapsNum)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .shift_en   (shift_en[gi]),
      .din        (din),
      .taps_next  (chan_taps[gi]),
      .count_next (chan_count[gi])
    );
  end

  // Pick the post-shift taps and count of the addressed channel.
  always_comb begin
    sel_taps  = '0;
    sel_count = '0;
    for (int c = 0; c < ChannelsNum; c++) begin
      if (in_chan == CHAN_W'(c)) begin
        sel_taps  = chan_taps[c];
        sel_count = chan_count[c];
      end
    end
  end

  // Output register next state: load on a valid accept, drain on out_ready, flag bad channels.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_chan_d   = out_chan_q;
    out_primed_d = out_primed_q;
    taps_d       = taps_q;
    chan_err_d   = chan_err_q;
    if (clear) begin
      out_valid_d  = 1'b0;
      out_chan_d   = '0;
      out_primed_d = 1'b0;
      taps_d       = '0;
      chan_err_d   = 1'b0;
    end else if (accept && chan_ok) begin
      out_valid_d  = 1'b1;
      out_chan_d   = in_chan;
      out_primed_d = (sel_count == CntW'(TapsNum));
      taps_d       = sel_taps;
    end else begin
      if (accept) begin
        chan_err_d = 1'b1;
      end
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output and error-flag registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      out_primed_q <= 1'b0;
      taps_q       <= '0;
      chan_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      out_primed_q <= out_primed_d;
      taps_q       <= taps_d;
      chan_err_q   <= chan_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_chan   = out_chan_q;
  assign out_primed = out_primed_q;
  assign taps       = taps_q;
  assign chan_err   = chan_err_q;

  // Symmetric pre-add from the registered taps; sign-extended so the sum cannot overflow.
  for (genvar gi = 0; gi < FOLD_N; gi++) begin : g_fold
    if (!Fold) begin : g_off
      assign fold[gi] = '0;
    end else if (gi == TapsNum - 1 - gi) begin : g_mid
      assign fold[gi] = {taps_q[gi][DataWidth-1], taps_q[gi]};
    end else begin : g_pair
      assign fold[gi] = {taps_q[gi][DataWidth-1], taps_q[gi]}
                      + {taps_q[TapsNum-1-gi][DataWidth-1], taps_q[TapsNum-1-gi]};
    end
  end

endmodule
